ow_p2s_writer: RTL and testbench

Parallel-to-serial 1-Wire write engine: latches a WIDTH-bit word on `start` and emits it LSB-first as back-to-back 1-Wire write time slots on an open-drain bus-low enable. It is the transmit-side counterpart to the bit-to-word serial-to-parallel path in the 1-Wire controller, and sits between the command sequencer and the DQ pad's open-drain driver. An optional bus reset/presence phase can precede the data slots.

---
 rtl/ow_p2s_writer.sv | 139 +++++++++++++
 tb/tb_ow_p2s_writer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ow_p2s_writer.sv
// 1-Wire parallel-to-serial write engine: shifts a latched word out LSB-first as write time slots.
// Optional bus reset/presence prefix enabled by defining OW_P2S_RESET_PULSE_EN.
module ow_p2s_writer #(
    parameter int WIDTH           = 16,
    parameter int LOW1_CYC        = 6,
    parameter int LOW0_CYC        = 60,
    parameter int SLOT_CYC        = 70,
    parameter int RST_LOW_CYC     = 480,
    parameter int RST_WAIT_CYC    = 480,
    parameter int PRES_SAMPLE_CYC = 70
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dq_in,
    output logic             bus_low_en,
    output logic             busy,
    output logic             done,
    output logic             presence
);
    localparam int M1   = (SLOT_CYC > RST_LOW_CYC) ? SLOT_CYC : RST_LOW_CYC;
    localparam int M2   = (M1 > RST_WAIT_CYC) ? M1 : RST_WAIT_CYC;
    localparam int MAXC = (M2 > PRES_SAMPLE_CYC) ? M2 : PRES_SAMPLE_CYC;
    localparam int TW   = $clog2(MAXC) + 1;
    localparam int BW   = $clog2(WIDTH) + 1;

    // Terminal counts: each phase lasts (END + 1) cycles.
    localparam logic [TW-1:0] L1_END = TW'(LOW1_CYC - 1);
    localparam logic [TW-1:0] L0_END = TW'(LOW0_CYC - 1);
    localparam logic [TW-1:0] H1_END = TW'(SLOT_CYC - LOW1_CYC - 1);
    localparam logic [TW-1:0] H0_END = TW'(SLOT_CYC - LOW0_CYC - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
`ifdef OW_P2S_RESET_PULSE_EN
        RST_LOW,
        RST_WAIT,
`endif
        SLOT_LOW,
        SLOT_HIGH
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [TW-1:0]    cnt;
    logic [BW-1:0]    bit_cnt;

`ifdef OW_P2S_RESET_PULSE_EN
    localparam logic [TW-1:0] RL_END = TW'(RST_LOW_CYC - 1);
    localparam logic [TW-1:0] RW_END = TW'(RST_WAIT_CYC - 1);
    localparam logic [TW-1:0] PS_AT  = TW'(PRES_SAMPLE_CYC);
`else
    logic dq_unused;
    assign dq_unused = dq_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            bit_cnt    <= '0;
            bus_low_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            presence   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg      <= data_in;
                        bit_cnt    <= '0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        bus_low_en <= 1'b1;
`ifdef OW_P2S_RESET_PULSE_EN
                        presence   <= 1'b0;
                        state      <= RST_LOW;
`else
                        state      <= SLOT_LOW;
`endif
                    end
                end
`ifdef OW_P2S_RESET_PULSE_EN
                RST_LOW: begin
                    if (cnt == RL_END) begin
                        cnt        <= '0;
                        bus_low_en <= 1'b0;
                        state      <= RST_WAIT;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                RST_WAIT: begin
                    if (cnt == PS_AT) presence <= ~dq_in;
                    if (cnt == RW_END) begin
                        cnt        <= '0;
                        bus_low_en <= 1'b1;
                        state      <= SLOT_LOW;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
`endif
                SLOT_LOW: begin
                    if (cnt == (shreg[0] ? L1_END : L0_END)) begin
                        cnt        <= '0;
                        bus_low_en <= 1'b0;
                        state      <= SLOT_HIGH;
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                SLOT_HIGH: begin
                    // Recovery length still keyed off the current bit; shift happens at slot end.
                    if (cnt == (shreg[0] ? H1_END : H0_END)) begin
                        cnt     <= '0;
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            bus_low_en <= 1'b1;
                            state      <= SLOT_LOW;
                        end
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ow_p2s_writer.sv
// Self-checking bench for ow_p2s_writer (default build): bus waveform checked cycle by cycle.
module tb_ow_p2s_writer;
    localparam int W    = 16;
    localparam int SLOT = 70;
    localparam int XFER = W * SLOT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         dq_in = 1'b1;
    logic         bus_low_en, busy, done, presence;

    int passed = 0;
    int total  = 0;

    logic bus_log  [0:2400];
    logic busy_log [0:2400];
    logic done_log [0:2400];

    always #5 clk = ~clk;

    ow_p2s_writer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in), .dq_in(dq_in),
        .bus_low_en(bus_low_en), .busy(busy), .done(done), .presence(presence)
    );

    // Reference: cycle k after acceptance lies in slot k/70 at offset k%70; low while offset < low time.
    function automatic logic exp_bus(input logic [W-1:0] w, input int k);
        if (k >= XFER) return 1'b0;
        return ((k % SLOT) < (w[k / SLOT] ? 6 : 60)) ? 1'b1 : 1'b0;
    endfunction

    function automatic int slot_errs(input logic [W-1:0] w, input int base, input int s);
        int e = 0;
        for (int j = 0; j < SLOT; j++)
            if (bus_log[base + s*SLOT + j] !== exp_bus(w, s*SLOT + j)) e++;
        return e;
    endfunction

    function automatic int low_cnt(input int base, input int s);
        int c = 0;
        for (int j = 0; j < SLOT; j++)
            if (bus_log[base + s*SLOT + j] === 1'b1) c++;
        return c;
    endfunction

    // Issue start with w, then log n cycles; optionally raise start again with inj_w at cycle inj_k.
    task automatic capture(input logic [W-1:0] w, input int n, input int inj_k, input logic [W-1:0] inj_w);
        @(negedge clk); start = 1'b1; data_in = w;
        @(posedge clk);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus_log[k] = bus_low_en; busy_log[k] = busy; done_log[k] = done;
            if (k == inj_k) begin start = 1'b1; data_in = inj_w; end
            else begin start = 1'b0; data_in = W'($urandom); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus_low_en === 1'b0) passed++; else $display("FAIL reset_bus got %b want 0", bus_low_en);
        total++; if (busy === 1'b0) passed++; else $display("FAIL reset_busy got %b want 0", busy);
        total++; if (done === 1'b0) passed++; else $display("FAIL reset_done got %b want 0", done);
        total++; if (presence === 1'b0) passed++; else $display("FAIL reset_presence got %b want 0", presence);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word(input logic [W-1:0] w, input string name);
        int bc;
        capture(w, XFER + 2, -1, '0);
        for (int s = 0; s < W; s++) begin
            int e = slot_errs(w, 0, s);
            total++;
            if (e == 0) passed++;
            else $display("FAIL %s_slot%0d low=%0d want %0d (bad cycles %0d)", name, s, low_cnt(0, s), w[s] ? 6 : 60, e);
        end
        bc = 0;
        for (int k = 0; k < XFER + 2; k++) if (busy_log[k] === 1'b1) bc++;
        total++; if (bc == XFER && busy_log[XFER-1] === 1'b1) passed++;
        else $display("FAIL %s_busy_len got %0d want %0d", name, bc, XFER);
        total++; if (done_log[XFER] === 1'b1 && done_log[XFER-1] === 1'b0) passed++;
        else $display("FAIL %s_done got %b%b want 01", name, done_log[XFER-1], done_log[XFER]);
        total++; if (done_log[XFER+1] === 1'b0) passed++;
        else $display("FAIL %s_done_drop got %b want 0", name, done_log[XFER+1]);
        total++; if (presence === 1'b0) passed++;
        else $display("FAIL %s_presence got %b want 0", name, presence);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) test_word(W'($urandom), "rand");
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] w;
        int late;
        w = W'($urandom);
        capture(w, XFER + 12, 300, ~w);
        for (int s = 0; s < W; s++) begin
            int e = slot_errs(w, 0, s);
            total++;
            if (e == 0) passed++;
            else $display("FAIL ign_slot%0d low=%0d want %0d", s, low_cnt(0, s), w[s] ? 6 : 60);
        end
        total++; if (done_log[XFER] === 1'b1) passed++;
        else $display("FAIL ign_done got %b want 1", done_log[XFER]);
        late = 0;
        for (int k = XFER; k < XFER + 12; k++) if (busy_log[k] !== 1'b0 || bus_log[k] !== 1'b0) late++;
        total++; if (late == 0) passed++;
        else $display("FAIL ign_idle_after got %0d active cycles want 0", late);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1, w2;
        int b2;
        w1 = W'($urandom); w2 = ~w1 ^ W'(16'h0F0F);
        b2 = XFER + 1;
        capture(w1, b2 + XFER + 2, XFER, w2);
        for (int s = 0; s < W; s++) begin
            int e1 = slot_errs(w1, 0, s);
            int e2 = slot_errs(w2, b2, s);
            total++;
            if (e1 == 0 && e2 == 0) passed++;
            else $display("FAIL b2b_slot%0d low1=%0d want %0d low2=%0d want %0d", s,
                          low_cnt(0, s), w1[s] ? 6 : 60, low_cnt(b2, s), w2[s] ? 6 : 60);
        end
        total++; if (bus_log[b2] === 1'b1 && busy_log[b2] === 1'b1) passed++;
        else $display("FAIL b2b_no_gap got bus=%b busy=%b want 1 1", bus_log[b2], busy_log[b2]);
        total++; if (done_log[b2 + XFER] === 1'b1) passed++;
        else $display("FAIL b2b_done2 got %b want 1", done_log[b2 + XFER]);
    endtask

    task automatic test_reset_mid();
        @(negedge clk); start = 1'b1; data_in = '0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        total++; if (bus_low_en === 1'b1 && busy === 1'b1) passed++;
        else $display("FAIL rmid_pre got bus=%b busy=%b want 1 1", bus_low_en, busy);
        rst_n = 1'b0;
        #1;
        total++; if (bus_low_en === 1'b0 && busy === 1'b0 && done === 1'b0) passed++;
        else $display("FAIL rmid_async got bus=%b busy=%b done=%b want 0 0 0", bus_low_en, busy, done);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy === 1'b0 && done === 1'b0) passed++;
        else $display("FAIL rmid_idle got busy=%b done=%b want 0 0", busy, done);
        test_word(16'h00FF, "rmid_after");
    endtask

    initial begin
        test_reset();
        test_word(16'hA5C3, "a5c3");
        test_word(16'h0000, "zero");
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
